// File: rtl/uart_tx_datapath.sv
// ----------------------------------------------------------------------------
// uart_tx_datapath
//
// Purpose:
//   Transmit-side datapath of a UART. Captures one parallel payload, computes
//   its parity, shifts it out LSB first under control of an external TX
//   control FSM and drives the registered serial line. An internal
//   EMPTY/LOADED/SHIFT/TAIL FSM tracks the held frame so that a new payload
//   can only be captured once the previous frame has been fully sent.
//
// Parameters:
//   DATA_WIDTH  payload width in bits (5..8)
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active low
//   P_DATA      in   parallel payload, sampled only on capture
//   Data_Valid  in   payload strobe, honoured only in EMPTY
//   PAR_TYP     in   parity type (0 even, 1 odd), sampled with P_DATA
//   ser_en      in   shift enable from the TX control FSM
//   mux_sel     in   line source: 11 start, 01 data, 00 parity, 10 idle/stop
//   ser_done    out  high while the last payload bit is being presented
//   TX_OUT      out  registered serial line
// ----------------------------------------------------------------------------
module uart_tx_datapath #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_TYP,
  input  logic                  ser_en,
  input  logic [1:0]            mux_sel,
  output logic                  ser_done,
  output logic                  TX_OUT
);

  // Counter only ever needs to reach DATA_WIDTH-1.
  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(DATA_WIDTH - 1);

  localparam logic [1:0] MuxStart  = 2'b11;
  localparam logic [1:0] MuxData   = 2'b01;
  localparam logic [1:0] MuxParity = 2'b00;
  localparam logic [1:0] MuxIdle   = 2'b10;

  typedef enum logic [1:0] {
    StEmpty,
    StLoaded,
    StShift,
    StTail
  } state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic [CntW-1:0]       r_count;
  logic [CntW-1:0]       w_count_next;
  logic                  r_parity;
  logic                  w_parity_next;
  logic                  r_tx;
  logic                  w_tx_next;
  logic                  w_last_bit;

  // Last payload bit is on bit 0 of the shift register.
  assign w_last_bit = (r_state == StShift) && (r_count == LastIdx);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StEmpty: begin
        if (Data_Valid) begin
          w_state_next = StLoaded;
        end
      end
      StLoaded: begin
        if (ser_en) begin
          w_state_next = StShift;
        end
      end
      StShift: begin
        // Leaves on the last bit regardless of ser_en.
        if (w_last_bit) begin
          w_state_next = StTail;
        end
      end
      StTail: begin
        if (mux_sel == MuxIdle) begin
          w_state_next = StEmpty;
        end
      end
      default: w_state_next = StEmpty;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    ser_done = w_last_bit;
  end

  // --------------------------------------------------------------------------
  // Payload shift register, bit counter and parity
  // --------------------------------------------------------------------------
  always_comb begin
    w_shift_next  = r_shift;
    w_count_next  = r_count;
    w_parity_next = r_parity;
    case (r_state)
      StEmpty: begin
        if (Data_Valid) begin
          w_shift_next  = P_DATA;
          w_parity_next = (^P_DATA) ^ PAR_TYP;
          w_count_next  = '0;
        end
      end
      StLoaded: begin
        if (ser_en) begin
          w_shift_next = {1'b0, r_shift[DATA_WIDTH-1:1]};
          w_count_next = CntW'(1);
        end
      end
      StShift: begin
        if (w_last_bit) begin
          // No shift here: bit DATA_WIDTH-1 stays on bit 0 through TAIL.
          w_count_next = '0;
        end else if (ser_en) begin
          w_shift_next = {1'b0, r_shift[DATA_WIDTH-1:1]};
          w_count_next = r_count + CntW'(1);
        end
      end
      StTail: begin
        w_shift_next = r_shift;
      end
      default: begin
        w_shift_next = r_shift;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift  <= '0;
      r_count  <= '0;
      r_parity <= 1'b0;
    end else begin
      r_shift  <= w_shift_next;
      r_count  <= w_count_next;
      r_parity <= w_parity_next;
    end
  end

  // --------------------------------------------------------------------------
  // Serial line mux, registered so TX_OUT is glitch free and has no
  // combinational path from any input.
  // --------------------------------------------------------------------------
  always_comb begin
    w_tx_next = 1'b1;
    case (mux_sel)
      MuxStart:  w_tx_next = 1'b0;
      MuxData:   w_tx_next = r_shift[0];
      MuxParity: w_tx_next = r_parity;
      MuxIdle:   w_tx_next = 1'b1;
      default:   w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx <= 1'b1;
    end else begin
      r_tx <= w_tx_next;
    end
  end

  assign TX_OUT = r_tx;

  // Counter must never run past the last payload index.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (r_count <= LastIdx);
    end
  end

endmodule

// File: tb/tb_uart_tx_datapath.sv
module tb_uart_tx_datapath;

  logic       clk;
  logic       rst;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_TYP;
  logic       ser_en;
  logic [1:0] mux_sel;
  logic       ser_done;
  logic       TX_OUT;

  int checks;
  int errors;

  uart_tx_datapath #(
    .DATA_WIDTH(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_TYP   (PAR_TYP),
    .ser_en    (ser_en),
    .mux_sel   (mux_sel),
    .ser_done  (ser_done),
    .TX_OUT    (TX_OUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle, entered and left at posedge+1. ser_done is sampled
  // mid-cycle (it reflects the current state); TX_OUT just after the edge.
  task automatic step(input logic [1:0] ms, input logic en, input logic dv,
                      input logic [7:0] pd, input logic pt,
                      output logic tx, output logic dn);
    mux_sel    = ms;
    ser_en     = en;
    Data_Valid = dv;
    P_DATA     = pd;
    PAR_TYP    = pt;
    #4;
    dn = ser_done;
    @(posedge clk);
    #1;
    tx = TX_OUT;
  endtask

  // Plays the control FSM for one frame: capture, start, 8 data, optional
  // parity, stop. Optional 2-cycle ser_en pause before data index pause_at,
  // and a stray Data_Valid (P_DATA=FF, PAR_TYP=1) at data index dv_at.
  task automatic run_frame(input logic [7:0] pd, input logic pt, input logic with_par,
                           input int pause_at, input int dv_at,
                           output logic start_tx, output logic [7:0] data_tx,
                           output logic par_tx, output logic stop_tx,
                           output int done_cnt, output logic done_last,
                           output logic [1:0] pause_tx);
    logic tx;
    logic dn;
    done_cnt  = 0;
    done_last = 1'b0;
    pause_tx  = 2'b00;
    par_tx    = 1'b0;
    data_tx   = 8'h00;
    step(2'b10, 1'b0, 1'b1, pd, pt, tx, dn);
    if (dn) done_cnt++;
    step(2'b11, 1'b0, 1'b0, 8'h00, 1'b0, start_tx, dn);
    if (dn) done_cnt++;
    for (int i = 0; i < 8; i++) begin
      if (i == pause_at) begin
        step(2'b01, 1'b0, 1'b0, 8'h00, 1'b0, tx, dn);
        pause_tx[0] = tx;
        if (dn) done_cnt++;
        step(2'b01, 1'b0, 1'b0, 8'h00, 1'b0, tx, dn);
        pause_tx[1] = tx;
        if (dn) done_cnt++;
      end
      step(2'b01, 1'b1, (i == dv_at), 8'hFF, (i == dv_at), tx, dn);
      data_tx[i] = tx;
      if (dn) done_cnt++;
      if (i == 7) done_last = dn;
    end
    if (with_par) begin
      step(2'b00, 1'b0, 1'b0, 8'h00, 1'b0, par_tx, dn);
      if (dn) done_cnt++;
    end
    step(2'b10, 1'b0, 1'b0, 8'h00, 1'b0, stop_tx, dn);
    if (dn) done_cnt++;
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    mux_sel    = 2'b01;
    ser_en     = 1'b0;
    Data_Valid = 1'b0;
    P_DATA     = 8'h00;
    PAR_TYP    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (TX_OUT !== 1'b1) begin
      errors++;
      $display("FAIL reset_tx: got %b want 1", TX_OUT);
    end
    checks++;
    if (ser_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b want 0", ser_done);
    end
    @(negedge clk);
    rst     = 1'b1;
    mux_sel = 2'b10;
    @(posedge clk);
    #1;
  endtask

  task automatic test_a5_even();
    logic st, pr, sp, dl;
    logic [7:0] d;
    logic [1:0] pz;
    int dc;
    run_frame(8'hA5, 1'b0, 1'b1, -1, -1, st, d, pr, sp, dc, dl, pz);
    checks++;
    if (st !== 1'b0) begin errors++; $display("FAIL a5e_start: got %b want 0", st); end
    checks++;
    if (d !== 8'hA5) begin errors++; $display("FAIL a5e_data: got %h want a5", d); end
    checks++;
    if (pr !== 1'b0) begin errors++; $display("FAIL a5e_parity: got %b want 0", pr); end
    checks++;
    if (sp !== 1'b1) begin errors++; $display("FAIL a5e_stop: got %b want 1", sp); end
    checks++;
    if (dc !== 1) begin errors++; $display("FAIL a5e_done_cnt: got %0d want 1", dc); end
    checks++;
    if (dl !== 1'b1) begin errors++; $display("FAIL a5e_done_last: got %b want 1", dl); end
  endtask

  task automatic test_a5_odd();
    logic st, pr, sp, dl;
    logic [7:0] d;
    logic [1:0] pz;
    int dc;
    run_frame(8'hA5, 1'b1, 1'b1, -1, -1, st, d, pr, sp, dc, dl, pz);
    checks++;
    if (pr !== 1'b1) begin errors++; $display("FAIL a5o_parity: got %b want 1", pr); end
    checks++;
    if (d !== 8'hA5) begin errors++; $display("FAIL a5o_data: got %h want a5", d); end
  endtask

  task automatic test_zero_no_parity();
    logic st, pr, sp, dl;
    logic [7:0] d;
    logic [1:0] pz;
    int dc;
    run_frame(8'h00, 1'b1, 1'b0, -1, -1, st, d, pr, sp, dc, dl, pz);
    checks++;
    if (st !== 1'b0) begin errors++; $display("FAIL zero_start: got %b want 0", st); end
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL zero_data: got %h want 00", d); end
    checks++;
    if (sp !== 1'b1) begin errors++; $display("FAIL zero_stop: got %b want 1", sp); end
    checks++;
    if (dc !== 1) begin errors++; $display("FAIL zero_done_cnt: got %0d want 1", dc); end
  endtask

  task automatic test_dv_ignored();
    logic st, pr, sp, dl;
    logic [7:0] d;
    logic [1:0] pz;
    int dc;
    run_frame(8'h3C, 1'b0, 1'b1, -1, 3, st, d, pr, sp, dc, dl, pz);
    checks++;
    if (d !== 8'h3C) begin errors++; $display("FAIL dvign_data: got %h want 3c", d); end
    checks++;
    if (pr !== 1'b0) begin errors++; $display("FAIL dvign_parity: got %b want 0", pr); end
    run_frame(8'hC3, 1'b1, 1'b1, -1, -1, st, d, pr, sp, dc, dl, pz);
    checks++;
    if (d !== 8'hC3) begin errors++; $display("FAIL dvign_next_data: got %h want c3", d); end
    checks++;
    if (pr !== 1'b1) begin errors++; $display("FAIL dvign_next_parity: got %b want 1", pr); end
  endtask

  task automatic test_pause();
    logic st, pr, sp, dl;
    logic [7:0] d;
    logic [1:0] pz;
    int dc;
    // 0x7B bit 4 is 1, so the held bit shows on the line during the pause.
    run_frame(8'h7B, 1'b0, 1'b1, 4, -1, st, d, pr, sp, dc, dl, pz);
    checks++;
    if (d !== 8'h7B) begin errors++; $display("FAIL pause_data: got %h want 7b", d); end
    checks++;
    if (pz !== 2'b11) begin errors++; $display("FAIL pause_hold: got %b want 11", pz); end
    checks++;
    if (dc !== 1) begin errors++; $display("FAIL pause_done_cnt: got %0d want 1", dc); end
    checks++;
    if (dl !== 1'b1) begin errors++; $display("FAIL pause_done_last: got %b want 1", dl); end
    checks++;
    if (pr !== 1'b0) begin errors++; $display("FAIL pause_parity: got %b want 0", pr); end
  endtask

  task automatic test_reset_mid();
    logic tx, dn, st, pr, sp, dl;
    logic [7:0] d;
    logic [1:0] pz;
    logic [2:0] bits;
    int dc;
    step(2'b10, 1'b0, 1'b1, 8'h96, 1'b0, tx, dn);
    step(2'b11, 1'b0, 1'b0, 8'h00, 1'b0, tx, dn);
    for (int i = 0; i < 3; i++) begin
      step(2'b01, 1'b1, 1'b0, 8'h00, 1'b0, tx, dn);
      bits[i] = tx;
    end
    checks++;
    if (bits !== 3'b110) begin errors++; $display("FAIL rmid_bits: got %b want 110", bits); end
    rst = 1'b0;
    #1;
    checks++;
    if (TX_OUT !== 1'b1) begin errors++; $display("FAIL rmid_tx: got %b want 1", TX_OUT); end
    checks++;
    if (ser_done !== 1'b0) begin errors++; $display("FAIL rmid_done: got %b want 0", ser_done); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      step(2'b10, 1'b0, 1'b0, 8'h00, 1'b0, tx, dn);
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL rmid_idle: got %b want 1", tx); end
    end
    run_frame(8'h5A, 1'b0, 1'b1, -1, -1, st, d, pr, sp, dc, dl, pz);
    checks++;
    if (d !== 8'h5A) begin errors++; $display("FAIL rmid_new_data: got %h want 5a", d); end
    checks++;
    if (pr !== 1'b0) begin errors++; $display("FAIL rmid_new_parity: got %b want 0", pr); end
    checks++;
    if (dc !== 1) begin errors++; $display("FAIL rmid_new_done: got %0d want 1", dc); end
  endtask

  task automatic test_reset_at_done();
    logic tx, dn, st, pr, sp, dl;
    logic [7:0] d;
    logic [1:0] pz;
    int dc;
    step(2'b10, 1'b0, 1'b1, 8'h00, 1'b0, tx, dn);
    step(2'b11, 1'b0, 1'b0, 8'h00, 1'b0, tx, dn);
    for (int i = 0; i < 7; i++) begin
      step(2'b01, 1'b1, 1'b0, 8'h00, 1'b0, tx, dn);
    end
    checks++;
    if (ser_done !== 1'b1) begin errors++; $display("FAIL rdone_pre: got %b want 1", ser_done); end
    rst = 1'b0;
    #1;
    checks++;
    if (TX_OUT !== 1'b1) begin errors++; $display("FAIL rdone_tx: got %b want 1", TX_OUT); end
    checks++;
    if (ser_done !== 1'b0) begin errors++; $display("FAIL rdone_done: got %b want 0", ser_done); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_frame(8'h0F, 1'b0, 1'b0, -1, -1, st, d, pr, sp, dc, dl, pz);
    checks++;
    if (d !== 8'h0F) begin errors++; $display("FAIL rdone_new_data: got %h want 0f", d); end
  endtask

  task automatic test_back_to_back();
    logic st, pr, sp, dl;
    logic [7:0] d;
    logic [1:0] pz;
    int dc;
    run_frame(8'h12, 1'b1, 1'b1, -1, -1, st, d, pr, sp, dc, dl, pz);
    checks++;
    if (d !== 8'h12) begin errors++; $display("FAIL b2b_data0: got %h want 12", d); end
    checks++;
    if (pr !== 1'b1) begin errors++; $display("FAIL b2b_parity0: got %b want 1", pr); end
    run_frame(8'hED, 1'b0, 1'b1, -1, -1, st, d, pr, sp, dc, dl, pz);
    checks++;
    if (st !== 1'b0) begin errors++; $display("FAIL b2b_start1: got %b want 0", st); end
    checks++;
    if (d !== 8'hED) begin errors++; $display("FAIL b2b_data1: got %h want ed", d); end
    checks++;
    if (pr !== 1'b0) begin errors++; $display("FAIL b2b_parity1: got %b want 0", pr); end
    checks++;
    if (sp !== 1'b1) begin errors++; $display("FAIL b2b_stop1: got %b want 1", sp); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_a5_even();
    test_a5_odd();
    test_zero_no_parity();
    test_dv_ignored();
    test_pause();
    test_reset_mid();
    test_reset_at_done();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_datapath.md
UART_TX_DATAPATH -- requirements
Module: uart_tx_datapath

Interface
REQ-001 Parameter DATA_WIDTH, default 8, frame payload width in bits (legal 5..8).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 P_DATA  input  DATA_WIDTH  parallel payload, sampled only when captured.
REQ-005 Data_Valid  input  1  P_DATA valid strobe.
REQ-006 PAR_TYP  input  1  parity type (0 even, 1 odd), sampled with P_DATA.
REQ-007 ser_en  input  1  shift enable from the TX control FSM.
REQ-008 mux_sel  input  2  line source select from the TX control FSM: 11 start bit (0), 01 serial data, 00 parity bit, 10 idle/stop (1).
REQ-009 ser_done  output  1  high while the last payload bit is presented.
REQ-010 TX_OUT  output  1  registered serial line.

Function
REQ-011 Internal control FSM: states EMPTY, LOADED, SHIFT, TAIL.
REQ-012 EMPTY: Data_Valid=1 -> capture P_DATA into shift register, compute parity, clear bit counter, go LOADED.
REQ-013 Data_Valid is ignored in LOADED, SHIFT and TAIL; no recapture and no corruption of the held frame.
REQ-014 LOADED: ser_en=1 -> shift register right by one, counter to 1, go SHIFT; ser_en=0 -> hold.
REQ-015 SHIFT: each cycle with ser_en=1 -> shift right by one, counter +1; ser_en=0 -> hold contents and counter.
REQ-016 Serial data bit is shift register bit 0, so the payload goes LSB first.
REQ-017 ser_done = 1 combinationally when in SHIFT and counter = DATA_WIDTH-1; else 0.
REQ-018 SHIFT with counter = DATA_WIDTH-1 -> go TAIL and clear counter next edge, whatever ser_en is; no shift on that edge.
REQ-019 TAIL: mux_sel=10 -> go EMPTY; otherwise hold. Shift register keeps bit DATA_WIDTH-1 at bit 0 until EMPTY.
REQ-020 Parity bit = XOR of the captured payload XOR PAR_TYP; registered at capture; stable until the next capture.
REQ-021 TX_OUT next value per mux_sel: 11 -> 0, 01 -> serial data bit, 00 -> parity bit, 10 -> 1.
REQ-022 TX_OUT has exactly one cycle latency from mux_sel for every field; no combinational path from any input to TX_OUT.
REQ-023 Counter width = ceil(log2(DATA_WIDTH)) bits; counter never exceeds DATA_WIDTH-1 and never wraps.
REQ-024 With the control FSM sequence start (1 cycle), data (DATA_WIDTH cycles ending on ser_done), optional parity, stop: exactly DATA_WIDTH payload bits appear on TX_OUT.
REQ-025 Back-to-back: Data_Valid in the first cycle after entering EMPTY is captured normally.

Reset
REQ-026 rst=0 asynchronously forces state EMPTY, shift register 0, counter 0, parity register 0, TX_OUT=1, ser_done=0.
REQ-027 Reset mid-frame discards the frame; after release, the next Data_Valid in EMPTY starts a clean frame.
REQ-028 TX_OUT stays 1 from reset release until a mux_sel other than 10 is applied.

Verification
REQ-029 P_DATA=0xA5, PAR_TYP=0, parity frame: TX_OUT = 0,1,0,1,0,0,1,0,1,0,1 (start, LSB-first data, parity 0, stop), each one cycle after its mux_sel; ser_done high in exactly one cycle.
REQ-030 P_DATA=0xA5, PAR_TYP=1: parity bit on TX_OUT = 1; data bits the same as REQ-029.
REQ-031 P_DATA=0x00, no parity (mux_sel 11, 01x8, 10): TX_OUT = 0, eight 0s, then 1; parity register is never selected.
REQ-032 Data_Valid pulsed with P_DATA=0xFF during SHIFT of 0x3C: transmitted payload stays 0x3C; the next capture happens only after return to EMPTY.
REQ-033 rst asserted after 3 data bits of 0x96: TX_OUT=1 and ser_done=0 at once; after release, frame 0x5A is transmitted correctly.
REQ-034 ser_en held low for 2 cycles in the middle of SHIFT: counter and data hold; ser_done still comes on the DATA_WIDTH-th enabled bit.
